mem2_load_capture: RTL

MEM2 pipeline stage register with a DCache load-response capture FSM, sitting between the MEM stage (which issues DCache reads) and WB. It latches MEM-stage fields and captures the DCache read data that returns while a load occupies MEM2. It requests a pipeline stall until that data is present, and drives the MEM2-side signals that WB consumes.

---
 rtl/mem2_load_capture.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem2_load_capture.sv
// MEM2 pipeline stage register with a DCache load-response capture FSM.
// Latches the MEM-stage fields, captures the read data that returns while a
// load occupies MEM2, and requests a stall until that data is present.
module mem2_load_capture (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM2_Flush,
  input  logic        MEM2_Wr,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_PC,
  input  logic [31:0] MEM_Instr,
  input  logic [31:0] MEM_OutB,
  input  logic [31:0] MEM_Result,
  input  logic [3:0]  MEM_LoadType,
  input  logic [1:0]  MEM_WbSel,
  input  logic [4:0]  MEM_Dst,
  input  logic [2:0]  MEM_RegsWrType,
  input  logic        MEM_IsLoad,
  input  logic        DC_RData_Valid,
  input  logic [31:0] DC_RData,
  input  logic        WB_Wr,
  output logic [31:0] MEM2_ALUOut,
  output logic [31:0] MEM2_PC,
  output logic [31:0] MEM2_Instr,
  output logic [31:0] MEM2_OutB,
  output logic [31:0] MEM2_Result,
  output logic [3:0]  MEM2_LoadType,
  output logic [1:0]  MEM2_WbSel,
  output logic [4:0]  MEM2_Dst,
  output logic [2:0]  MEM2_RegsWrType,
  output logic [31:0] MEM2_DMOut,
  output logic        MEM2_Stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no load pending
    S_WAIT = 2'd1,  // load in MEM2, data not yet returned
    S_HELD = 2'd2,  // data captured, waiting for WB to take it
    S_DROP = 2'd3   // flushed load still has a response in flight
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] dmout_reg;

  // WB acceptance is already folded into MEM2_Wr by the hazard unit; the
  // capture logic itself does not need it.
  logic        wb_wr_unused;
  assign wb_wr_unused = WB_Wr;

  // Stage field registers: flush clears, write loads, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MEM2_ALUOut     <= '0;
      MEM2_PC         <= '0;
      MEM2_Instr      <= '0;
      MEM2_OutB       <= '0;
      MEM2_Result     <= '0;
      MEM2_LoadType   <= '0;
      MEM2_WbSel      <= '0;
      MEM2_Dst        <= '0;
      MEM2_RegsWrType <= '0;
    end else if (MEM2_Flush) begin
      MEM2_ALUOut     <= '0;
      MEM2_PC         <= '0;
      MEM2_Instr      <= '0;
      MEM2_OutB       <= '0;
      MEM2_Result     <= '0;
      MEM2_LoadType   <= '0;
      MEM2_WbSel      <= '0;
      MEM2_Dst        <= '0;
      MEM2_RegsWrType <= '0;
    end else if (MEM2_Wr) begin
      MEM2_ALUOut     <= MEM_ALUOut;
      MEM2_PC         <= MEM_PC;
      MEM2_Instr      <= MEM_Instr;
      MEM2_OutB       <= MEM_OutB;
      MEM2_Result     <= MEM_Result;
      MEM2_LoadType   <= MEM_LoadType;
      MEM2_WbSel      <= MEM_WbSel;
      MEM2_Dst        <= MEM_Dst;
      MEM2_RegsWrType <= MEM_RegsWrType;
    end
  end

  // FSM state and captured load data; data is only kept for an unflushed load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      dmout_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_WAIT && DC_RData_Valid && !MEM2_Flush) begin
        dmout_reg <= DC_RData;
      end
    end
  end

  // Next-state logic plus the combinational bypass and stall outputs.
  always_comb begin
    state_next = state_reg;
    MEM2_DMOut = dmout_reg;
    MEM2_Stall = 1'b0;
    case (state_reg)
      S_IDLE, S_HELD: begin
        // A stray response here is a protocol error and is ignored.
        if (MEM2_Flush) begin
          state_next = S_IDLE;
        end else if (MEM2_Wr) begin
          state_next = MEM_IsLoad ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        if (DC_RData_Valid) begin
          MEM2_DMOut = DC_RData;
        end else begin
          MEM2_Stall = 1'b1;
        end
        if (MEM2_Flush) begin
          // A response arriving with the flush is consumed, nothing left to drop.
          state_next = DC_RData_Valid ? S_IDLE : S_DROP;
        end else if (DC_RData_Valid) begin
          if (MEM2_Wr) begin
            state_next = MEM_IsLoad ? S_WAIT : S_IDLE;
          end else begin
            state_next = S_HELD;
          end
        end
      end
      S_DROP: begin
        MEM2_Stall = 1'b1;
        if (DC_RData_Valid) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
